// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Holds the frame FSM states and the scan-code bytes the receiver treats specially.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_OVF0   = 8'h00;
    localparam logic [7:0] PS2_OVF1   = 8'hFF;

    // Keyboard housekeeping replies that carry no key information.
    function automatic logic is_discard(input logic [7:0] b);
        return (b == PS2_PAUSE)  || (b == PS2_ACK)  || (b == PS2_BAT_OK) ||
               (b == PS2_ECHO)   || (b == PS2_RESEND) ||
               (b == PS2_OVF0)   || (b == PS2_OVF1);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus debounce for one raw PS/2 pad line.
// The output follows the pad only after FILTER_LEN equal consecutive samples.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic i_line,
    output logic o_level
);

    localparam int             CW     = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0]  RELOAD = CW'(FILTER_LEN - 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    // Down-counter reloads whenever the synced line agrees with the accepted level.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[0], i_line};
            if (r_sync[1] == r_level) begin
                r_cnt <= RELOAD;
            end else if (r_cnt == '0) begin
                r_level <= r_sync[1];
                r_cnt   <= RELOAD;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver with E0/F0 prefix folding.
// Emits one registered strobe per scan code, or a frame_err pulse on a bad frame.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 48000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_strobe,
    output logic       key_pressed,
    output logic       key_extended,
    output logic [7:0] key_code,
    output logic       frame_err
);

    localparam int            TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT);

    logic w_clk_f;
    logic w_data_f;
    logic w_bit_edge;
    logic w_timeout;
    logic w_good;
    logic w_err;

    ps2_state_e    r_state;
    ps2_state_e    w_state_nxt;
    logic          r_clk_prev;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par_ok;
    logic [TW-1:0] r_timer;
    logic          r_ext;
    logic          r_brk;
    logic          r_strobe;
    logic          r_pressed;
    logic          r_extended;
    logic [7:0]    r_code;
    logic          r_err;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_sys (clk_sys),
        .reset   (reset),
        .i_line  (ps2_clk),
        .o_level (w_clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk_sys (clk_sys),
        .reset   (reset),
        .i_line  (ps2_data),
        .o_level (w_data_f)
    );

    assign w_bit_edge = r_clk_prev & ~w_clk_f;
    assign w_timeout  = (r_state != IDLE) && (r_timer == '0);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_clk_prev <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_clk_prev <= w_clk_f;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good      = 1'b0;
        w_err       = 1'b0;
        if (w_timeout) begin
            w_err       = 1'b1;
            w_state_nxt = IDLE;
        end else if (w_bit_edge) begin
            case (r_state)
                IDLE:    if (!w_data_f) w_state_nxt = DATA;
                DATA:    if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
                PARITY:  w_state_nxt = STOP;
                STOP: begin
                    if (w_data_f && r_par_ok) w_good = 1'b1;
                    else                      w_err  = 1'b1;
                    w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_ok   <= 1'b0;
            r_timer    <= '0;
            r_ext      <= 1'b0;
            r_brk      <= 1'b0;
            r_strobe   <= 1'b0;
            r_pressed  <= 1'b0;
            r_extended <= 1'b0;
            r_code     <= 8'h00;
            r_err      <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_bit_cnt <= '0;
            end else if (r_state == DATA && w_bit_edge) begin
                r_shift   <= {w_data_f, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (r_state == PARITY && w_bit_edge)
                r_par_ok <= ^{w_data_f, r_shift};

            // Any bit edge restarts the inter-edge budget; only non-IDLE states consume it.
            if (w_bit_edge)
                r_timer <= T_LOAD;
            else if (r_state != IDLE && r_timer != '0)
                r_timer <= r_timer - 1'b1;

            r_strobe <= 1'b0;
            r_err    <= w_err;
            if (w_err) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (w_good) begin
                if (r_shift == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (r_shift == PS2_BRK) begin
                    r_brk <= 1'b1;
                end else if (!is_discard(r_shift)) begin
                    r_strobe   <= 1'b1;
                    r_code     <= r_shift;
                    r_extended <= r_ext;
                    r_pressed  <= ~r_brk;
                    r_ext      <= 1'b0;
                    r_brk      <= 1'b0;
                end
            end
        end
    end

    assign key_strobe   = r_strobe;
    assign key_pressed  = r_pressed;
    assign key_extended = r_extended;
    assign key_code     = r_code;
    assign frame_err    = r_err;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: drives PS/2 frames bit by bit and checks decoded events.
module tb_ps2_rx;

    localparam int FL      = 8;
    localparam int TMO     = 400;
    localparam int HALF    = 40;
    localparam int GAP     = 100;

    logic       clk_sys;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       key_strobe;
    logic       key_pressed;
    logic       key_extended;
    logic [7:0] key_code;
    logic       frame_err;

    int n_vec  = 0;
    int n_bad  = 0;
    int n_strb = 0;
    int n_err  = 0;
    int n_both = 0;
    int s0;
    int e0;

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT(TMO)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .key_strobe   (key_strobe),
        .key_pressed  (key_pressed),
        .key_extended (key_extended),
        .key_code     (key_code),
        .frame_err    (frame_err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (key_strobe) n_strb++;
        if (frame_err)  n_err++;
        if (key_strobe && frame_err) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(1'b1);
        ps2_data = 1'b1;
        wait_cyc(GAP);
    endtask

    task automatic check_key(input string tag, input int strb_before,
                             input logic [7:0] code, input logic pressed, input logic ext);
        check({tag, "_cnt"},  n_strb - strb_before, 1);
        check({tag, "_code"}, key_code, code);
        check({tag, "_prs"},  key_pressed, pressed);
        check({tag, "_ext"},  key_extended, ext);
    endtask

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(5);
        check("rst_strobe", key_strobe, 0);
        check("rst_code",   key_code, 8'h00);
        check("rst_prs",    key_pressed, 0);
        check("rst_ext",    key_extended, 0);
        check("rst_err",    frame_err, 0);
        reset = 1'b0;
        wait_cyc(20);

        // plain make code
        s0 = n_strb; e0 = n_err;
        send_frame(8'h1C, 1'b0);
        check_key("make_1c", s0, 8'h1C, 1'b1, 1'b0);
        check("make_1c_err", n_err - e0, 0);

        // break prefix folded into the next code
        s0 = n_strb;
        send_frame(8'hF0, 1'b0);
        check("brk_no_strobe", n_strb - s0, 0);
        send_frame(8'h1C, 1'b0);
        check_key("brk_1c", s0, 8'h1C, 1'b0, 1'b0);

        // extended make, then extended break
        s0 = n_strb;
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        check_key("ext_make", s0, 8'h75, 1'b1, 1'b1);
        s0 = n_strb;
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        check_key("ext_brk", s0, 8'h75, 1'b0, 1'b1);

        // discarded housekeeping byte leaves flags intact
        s0 = n_strb;
        send_frame(8'hE0, 1'b0);
        send_frame(8'hFA, 1'b0);
        check("disc_no_strobe", n_strb - s0, 0);
        send_frame(8'h6B, 1'b0);
        check_key("disc_keep", s0, 8'h6B, 1'b1, 1'b1);

        // parity error clears the pending prefix
        s0 = n_strb; e0 = n_err;
        send_frame(8'hE0, 1'b0);
        send_frame(8'h1C, 1'b1);
        check("par_err_cnt", n_err - e0, 1);
        check("par_no_strobe", n_strb - s0, 0);
        send_frame(8'h1C, 1'b0);
        check_key("after_par", s0, 8'h1C, 1'b1, 1'b0);

        // timeout in the middle of the data bits
        s0 = n_strb; e0 = n_err;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        ps2_data = 1'b1;
        wait_cyc(TMO + 10 + 30);
        check("tmo_err_cnt", n_err - e0, 1);
        check("tmo_no_strobe", n_strb - s0, 0);
        send_frame(8'h1C, 1'b0);
        check_key("after_tmo", s0, 8'h1C, 1'b1, 1'b0);

        // short clock glitches with data low must not start a frame
        s0 = n_strb; e0 = n_err;
        ps2_data = 1'b0;
        wait_cyc(20);
        for (int i = 0; i < 3; i++) begin
            ps2_clk = 1'b0;
            wait_cyc(FL - 2);
            ps2_clk = 1'b1;
            wait_cyc(20);
        end
        ps2_data = 1'b1;
        wait_cyc(20);
        check("glitch_no_strobe", n_strb - s0, 0);
        check("glitch_no_err", n_err - e0, 0);
        send_frame(8'h2A, 1'b0);
        check_key("after_glitch", s0, 8'h2A, 1'b1, 1'b0);

        // reset mid-frame after an E0 prefix
        s0 = n_strb;
        send_frame(8'hE0, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        reset = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(3);
        check("mrst_code", key_code, 8'h00);
        check("mrst_prs",  key_pressed, 0);
        check("mrst_ext",  key_extended, 0);
        check("mrst_strobe", key_strobe, 0);
        check("mrst_err",  frame_err, 0);
        reset = 1'b0;
        wait_cyc(GAP);
        check("mrst_no_strobe", n_strb - s0, 0);
        send_frame(8'h1C, 1'b0);
        check_key("after_mrst", s0, 8'h1C, 1'b1, 1'b0);

        check("never_both", n_both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
